// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment capture path: digit count,
// active-high gfedcba segment patterns for each hex value, and FSM states.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } cap_state_t;

endpackage

// File: rtl/seg_to_nibble.sv
// Inverse of the display decoder: maps an active-high gfedcba pattern back to
// its hex nibble, flagging all-dark patterns separately from unknown ones.
module seg_to_nibble
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       hit,
  output logic       blank
);

  // Table lookup; anything not in the table is a miss with nibble 0.
  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    blank  = 1'b0;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        hit   = 1'b0;
        blank = 1'b1;
      end
      default:   hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Watches a multiplexed 8-digit seven-segment bus and recovers the nibble
// shown on each digit once its anode and segments have been stable long enough.
module seg_capture
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  AN,
  input  logic [6:0]  HEX,
  input  logic        DP,
  input  logic        clear,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic [7:0]  digit_err,
  output logic [7:0]  digit_blank,
  output logic [7:0]  dp_seen,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [7:0] an_meta, an_sync, an_norm;
  logic [6:0] hex_meta, hex_sync, seg_norm;
  logic       dp_meta, dp_sync, dp_norm;

  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             same;

  cap_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             load, capture;

  logic [IDX_W-1:0] lat_idx;
  logic [6:0]       lat_seg;
  logic             lat_dp;
  logic [7:0]       frame_mask;

  logic [3:0] dec_nibble;
  logic       dec_hit, dec_blank;

  // Two-flop synchronizers on every bus input; the bus is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_meta  <= '0;
      an_sync  <= '0;
      hex_meta <= '0;
      hex_sync <= '0;
      dp_meta  <= 1'b0;
      dp_sync  <= 1'b0;
    end else begin
      an_meta  <= AN;
      an_sync  <= an_meta;
      hex_meta <= HEX;
      hex_sync <= hex_meta;
      dp_meta  <= DP;
      dp_sync  <= dp_meta;
    end
  end

  assign an_norm  = AN_ACTIVE_LOW  ? ~an_sync  : an_sync;
  assign seg_norm = SEG_ACTIVE_LOW ? ~hex_sync : hex_sync;
  assign dp_norm  = SEG_ACTIVE_LOW ? ~dp_sync  : dp_sync;

  // A digit counts as selected only when exactly one anode is active.
  always_comb begin
    sel_valid = (an_norm != 8'h00) && ((an_norm & (an_norm - 8'd1)) == 8'h00);
    sel_idx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_norm[i]) sel_idx = IDX_W'(i);
    end
    same = sel_valid && (sel_idx == lat_idx) && (seg_norm == lat_seg) && (dp_norm == lat_dp);
  end

  // Next-state logic: latch on selection, count stable cycles, capture once.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_next = SETTLE;
          load       = 1'b1;
          cnt_next   = CNT_ONE;
        end
      end
      SETTLE, HELD: begin
        if (same) begin
          if (state == SETTLE) begin
            if (cnt >= CNT_MAX) begin
              capture    = 1'b1;
              state_next = HELD;
            end else begin
              cnt_next = cnt + CNT_ONE;
            end
          end
        end else if (sel_valid) begin
          state_next = SETTLE;
          load       = 1'b1;
          cnt_next   = CNT_ONE;
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, settle counter and the latched digit snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_idx <= '0;
      lat_seg <= '0;
      lat_dp  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load) begin
        lat_idx <= sel_idx;
        lat_seg <= seg_norm;
        lat_dp  <= dp_norm;
      end
    end
  end

  seg_to_nibble u_dec (
    .seg    (lat_seg),
    .nibble (dec_nibble),
    .hit    (dec_hit),
    .blank  (dec_blank)
  );

  // Capture results and frame tracking; clear wins over a same-cycle capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_valid <= '0;
      digit_err   <= '0;
      digit_blank <= '0;
      dp_seen     <= '0;
      frame_mask  <= '0;
      frame_done  <= 1'b0;
    end else if (clear) begin
      digit_valid <= '0;
      digit_err   <= '0;
      digit_blank <= '0;
      dp_seen     <= '0;
      frame_mask  <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= (frame_mask == 8'hFF);
      if (frame_mask == 8'hFF) frame_mask <= '0;
      if (capture) begin
        digit_valid[lat_idx] <= 1'b1;
        dp_seen[lat_idx]     <= lat_dp;
        frame_mask[lat_idx]  <= 1'b1;
        if (dec_hit || dec_blank) begin
          digits[{lat_idx, 2'b00} +: 4] <= dec_nibble;
          digit_err[lat_idx]            <= 1'b0;
          digit_blank[lat_idx]          <= dec_blank;
        end else begin
          digit_err[lat_idx]   <= 1'b1;
          digit_blank[lat_idx] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture with default parameters
// (settle 16 cycles, active-low anodes and segments).
module tb_seg_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  an = 8'hFF;
  logic [6:0]  hex = 7'h7F;
  logic        dp = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] digits;
  logic [7:0]  digit_valid, digit_err, digit_blank, dp_seen;
  logic        frame_done;

  int tests_run = 0;
  int tests_failed = 0;
  int frame_pulses = 0;
  int pulses_base = 0;

  logic [6:0] enc_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [3:0] m_digits [8];
  logic [7:0] m_valid, m_err, m_blank, m_dp, m_mask;
  int         m_frames;

  seg_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .AN          (an),
    .HEX         (hex),
    .DP          (dp),
    .clear       (clear),
    .digits      (digits),
    .digit_valid (digit_valid),
    .digit_err   (digit_err),
    .digit_blank (digit_blank),
    .dp_seen     (dp_seen),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // Count frame_done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && frame_done === 1'b1) frame_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_packed();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = m_digits[i];
    return v;
  endfunction

  task automatic model_clear_all();
    for (int i = 0; i < 8; i++) m_digits[i] = 4'h0;
    m_valid = '0; m_err = '0; m_blank = '0; m_dp = '0; m_mask = '0; m_frames = 0;
  endtask

  // Reference behaviour of one completed capture, written from the pattern table.
  task automatic model_capture(input int idx, input logic [6:0] pat, input logic dp_lit);
    bit found = 0;
    logic [3:0] nib = 4'h0;
    for (int v = 0; v < 16; v++) begin
      if (enc_tab[v] == pat) begin
        found = 1;
        nib = 4'(v);
      end
    end
    if (pat == 7'h00) begin
      m_digits[idx] = 4'h0; m_blank[idx] = 1'b1; m_err[idx] = 1'b0;
    end else if (found) begin
      m_digits[idx] = nib; m_blank[idx] = 1'b0; m_err[idx] = 1'b0;
    end else begin
      m_err[idx] = 1'b1; m_blank[idx] = 1'b0;
    end
    m_valid[idx] = 1'b1;
    m_dp[idx] = dp_lit;
    m_mask[idx] = 1'b1;
    if (m_mask == 8'hFF) begin
      m_frames++;
      m_mask = '0;
    end
  endtask

  // Show one digit on the pins for a number of cycles; long holds capture.
  task automatic show(input int idx, input logic [6:0] pat, input logic dp_lit, input int hold);
    an  = ~(8'h01 << idx);
    hex = ~pat;
    dp  = ~dp_lit;
    tick(hold);
    if (hold >= 19) model_capture(idx, pat, dp_lit);
  endtask

  task automatic drive_idle(input int n);
    an = 8'hFF; hex = 7'h7F; dp = 1'b1;
    tick(n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    an = 8'hFF; hex = 7'h7F; dp = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    model_clear_all();
    pulses_base = frame_pulses;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    an = 8'hFE; hex = ~7'h3F; dp = 1'b0;
    tick(3);
    tests_run++;
    if ({digits, digit_valid, digit_err, digit_blank, dp_seen, frame_done} !== 65'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got digits=%h valid=%h err=%h blank=%h dp=%h fd=%b, want all 0",
               digits, digit_valid, digit_err, digit_blank, dp_seen, frame_done);
    end
    do_reset();
    tests_run++;
    if ({digit_valid, frame_done} !== 9'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got valid=%h fd=%b, want 0", digit_valid, frame_done);
    end
  endtask

  task automatic test_static_digit();
    do_reset();
    an = 8'hFE; hex = ~7'h4F; dp = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (k == 18) begin
        tests_run++;
        if (digit_valid !== 8'h00) begin
          tests_failed++;
          $display("[TB] FAIL static_early: got valid=%h after 18 cycles, want 00", digit_valid);
        end
      end
      if (k == 19) begin
        tests_run++;
        if (digit_valid !== 8'h01) begin
          tests_failed++;
          $display("[TB] FAIL static_latency: got valid=%h after 19 cycles, want 01", digit_valid);
        end
      end
    end
    tests_run++;
    if ({digits[3:0], digit_err, dp_seen, digit_valid} !== {4'h3, 8'h00, 8'h00, 8'h01}) begin
      tests_failed++;
      $display("[TB] FAIL static_value: got nib=%h err=%h dp=%h valid=%h, want 3 00 00 01",
               digits[3:0], digit_err, dp_seen, digit_valid);
    end
  endtask

  task automatic test_full_scan();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      show(i, enc_tab[i+1], 1'b0, 20);
      if (i == 6) begin
        tests_run++;
        if (frame_pulses - pulses_base !== 0) begin
          tests_failed++;
          $display("[TB] FAIL scan_early_frame: got %0d pulses before digit 7, want 0",
                   frame_pulses - pulses_base);
        end
      end
    end
    drive_idle(5);
    tests_run++;
    if ({digits, digit_valid} !== {32'h87654321, 8'hFF}) begin
      tests_failed++;
      $display("[TB] FAIL scan_digits: got %h valid=%h, want 87654321 FF", digits, digit_valid);
    end
    tests_run++;
    if (frame_pulses - pulses_base !== 1) begin
      tests_failed++;
      $display("[TB] FAIL scan_frame: got %0d pulses, want 1", frame_pulses - pulses_base);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    an = 8'hFE; dp = 1'b1;
    for (int k = 0; k < 20; k++) begin
      hex = k[0] ? ~7'h5B : ~7'h06;
      tick(5);
    end
    tests_run++;
    if (digit_valid !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL glitch_reject: got valid=%h, want 00", digit_valid);
    end
  endtask

  task automatic test_bad_blank();
    do_reset();
    show(2, 7'h4F, 1'b0, 25);
    show(2, 7'h01, 1'b0, 25);
    tests_run++;
    if ({digit_err[2], digit_blank[2], digits[11:8]} !== {1'b1, 1'b0, 4'h3}) begin
      tests_failed++;
      $display("[TB] FAIL bad_pattern: got err=%b blank=%b nib=%h, want 1 0 3",
               digit_err[2], digit_blank[2], digits[11:8]);
    end
    show(2, 7'h00, 1'b0, 25);
    tests_run++;
    if ({digit_err[2], digit_blank[2], digits[11:8]} !== {1'b0, 1'b1, 4'h0}) begin
      tests_failed++;
      $display("[TB] FAIL blank_pattern: got err=%b blank=%b nib=%h, want 0 1 0",
               digit_err[2], digit_blank[2], digits[11:8]);
    end
  endtask

  task automatic test_non_onehot();
    do_reset();
    an = 8'hFC; hex = ~7'h3F; dp = 1'b1;
    tick(50);
    tests_run++;
    if (digit_valid !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL non_onehot: got valid=%h, want 00", digit_valid);
    end
    show(2, 7'h71, 1'b0, 25);
    tests_run++;
    if ({digits[11:8], digit_valid} !== {4'hF, 8'h04}) begin
      tests_failed++;
      $display("[TB] FAIL onehot_after: got nib=%h valid=%h, want F 04", digits[11:8], digit_valid);
    end
  endtask

  task automatic test_reset_mid_settle();
    do_reset();
    an = ~8'h20; hex = ~7'h6D; dp = 1'b0;
    tick(10);
    rst_n = 1'b0;
    tick(2);
    tests_run++;
    if ({digits, digit_valid, digit_err, digit_blank, dp_seen, frame_done} !== 65'h0) begin
      tests_failed++;
      $display("[TB] FAIL midsettle_reset: got digits=%h valid=%h dp=%h, want 0", digits, digit_valid, dp_seen);
    end
    an = 8'hFF; hex = 7'h7F; dp = 1'b1;
    rst_n = 1'b1;
    tick(30);
    tests_run++;
    if ({digits, digit_valid} !== 40'h0) begin
      tests_failed++;
      $display("[TB] FAIL midsettle_release: got digits=%h valid=%h, want 0", digits, digit_valid);
    end
  endtask

  task automatic test_clear();
    do_reset();
    show(0, 7'h00, 1'b0, 20);
    show(1, 7'h01, 1'b0, 20);
    show(2, enc_tab[9], 1'b1, 20);
    show(3, enc_tab[12], 1'b0, 20);
    tests_run++;
    if ({digit_valid, digit_blank, digit_err, dp_seen} !== {8'h0F, 8'h01, 8'h02, 8'h04}) begin
      tests_failed++;
      $display("[TB] FAIL clear_pre: got valid=%h blank=%h err=%h dp=%h, want 0F 01 02 04",
               digit_valid, digit_blank, digit_err, dp_seen);
    end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    m_valid = '0; m_err = '0; m_blank = '0; m_dp = '0; m_mask = '0;
    tests_run++;
    if ({digit_valid, digit_err, digit_blank, dp_seen, digits} !== {32'h0, model_packed()}) begin
      tests_failed++;
      $display("[TB] FAIL clear_flags: got valid=%h err=%h blank=%h dp=%h digits=%h, want 0 0 0 0 %h",
               digit_valid, digit_err, digit_blank, dp_seen, digits, model_packed());
    end
    for (int i = 4; i < 8; i++) show(i, enc_tab[i], 1'b0, 20);
    drive_idle(5);
    tests_run++;
    if (frame_pulses - pulses_base !== 0) begin
      tests_failed++;
      $display("[TB] FAIL clear_frame_hold: got %0d pulses, want 0", frame_pulses - pulses_base);
    end
    for (int i = 0; i < 4; i++) show(i, enc_tab[i], 1'b0, 20);
    drive_idle(5);
    tests_run++;
    if ({frame_pulses - pulses_base, digit_valid} !== {32'd1, 8'hFF}) begin
      tests_failed++;
      $display("[TB] FAIL clear_frame_after: got %0d pulses valid=%h, want 1 FF",
               frame_pulses - pulses_base, digit_valid);
    end
  endtask

  task automatic test_clear_priority();
    do_reset();
    an = ~8'h02; hex = ~7'h6D; dp = 1'b0;
    tick(18);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(10);
    tests_run++;
    if ({digit_valid, dp_seen} !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL clear_priority: got valid=%h dp=%h, want 00 00", digit_valid, dp_seen);
    end
  endtask

  task automatic test_random_scan();
    int idx = 0;
    int hold;
    logic [6:0] pat;
    logic dpl;
    do_reset();
    for (int s = 0; s < 40; s++) begin
      idx = (idx + 1 + int'($urandom % 7)) % 8;
      pat = ($urandom % 4 != 0) ? enc_tab[$urandom % 16] : 7'($urandom);
      dpl = 1'($urandom);
      hold = ($urandom % 3 != 0) ? int'($urandom_range(22, 30)) : int'($urandom_range(3, 10));
      show(idx, pat, dpl, hold);
      tests_run++;
      if ({digits, digit_valid, digit_err, digit_blank, dp_seen} !==
          {model_packed(), m_valid, m_err, m_blank, m_dp}) begin
        tests_failed++;
        $display("[TB] FAIL random_step%0d: got %h %h %h %h %h, want %h %h %h %h %h", s,
                 digits, digit_valid, digit_err, digit_blank, dp_seen,
                 model_packed(), m_valid, m_err, m_blank, m_dp);
      end
    end
    drive_idle(5);
    tests_run++;
    if (frame_pulses - pulses_base !== m_frames) begin
      tests_failed++;
      $display("[TB] FAIL random_frames: got %0d pulses, want %0d", frame_pulses - pulses_base, m_frames);
    end
  endtask

  initial begin
    test_reset();
    test_static_digit();
    test_full_scan();
    test_glitch();
    test_bad_blank();
    test_non_onehot();
    test_reset_mid_settle();
    test_clear();
    test_clear_priority();
    test_random_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Monitors a multiplexed 8-digit seven-segment bus (AN, HEX, DP) and recovers the nibble shown on each digit.
- It is the decode direction of the nibble-to-segment decoder used in the display path. It turns segment patterns back into hex values.
- Used in loopback builds and self-check: the display bus from the board-facing logic is routed back into this block, and the recovered digits are compared against the values that were meant to be shown.

Parameters:
- SETTLE_CYCLES, 16, consecutive stable cycles of anode+segments required before a digit is captured (range 1..65535)
- AN_ACTIVE_LOW, 1, 1: a digit is selected when its AN bit is 0; 0: selected when its AN bit is 1
- SEG_ACTIVE_LOW, 1, 1: a segment is lit when its HEX/DP bit is 0; 0: lit when 1

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- AN  input  8  digit select bus under observation; AN[i] selects digit i
- HEX  input  7  segment bus {g,f,e,d,c,b,a}
- DP  input  1  decimal point segment
- digits  output  32  recovered nibbles; digit i occupies digits[4i+3:4i]
- digit_valid  output  8  bit i set once digit i has been captured since reset/clear
- digit_err  output  8  bit i set if the last capture of digit i was an unrecognised pattern
- digit_blank  output  8  bit i set if the last capture of digit i had all segments dark
- dp_seen  output  8  DP lit state at the last capture of digit i
- frame_done  output  1  one-cycle pulse when all 8 digits have been captured since the previous pulse
- clear  input  1  synchronous; zeroes valid/err/blank/dp_seen and the frame mask

Behaviour:
- Reset:
  - The async rst_n clears all outputs and internal registers to 0.
  - The FSM goes to IDLE and the settle counter is 0.
- Input conditioning:
  - AN, HEX and DP each pass through a 2-flop synchronizer.
  - Polarity is then normalised to active-high using the parameters.
  - All further logic uses the normalised, synchronised values only.
- Digit index:
  - The index is valid only when the normalised AN is one-hot.
  - If AN is zero or has more than one bit set, no digit is selected.
- FSM states: IDLE, SETTLE, HELD.
  - IDLE -> SETTLE when a digit is selected. Latch the index, segments and DP, and set the counter to 1.
  - SETTLE, when the index, segments and DP are unchanged from the latch:
    - Increment the counter.
    - When the counter reaches SETTLE_CYCLES, capture and go to HELD.
    - With SETTLE_CYCLES=1, capture occurs on the cycle after the latch.
  - SETTLE, when anything changes:
    - If a digit is still selected, re-latch and restart the counter at 1 (stay in SETTLE).
    - Otherwise go to IDLE.
  - HELD: no further captures occur.
    - Any change in index, segments or DP -> treated exactly like the SETTLE change rules above.
    - No digit selected -> IDLE.
- Capture of digit i, with all registers updated in the same cycle:
  - digit_valid[i] is set to 1.
  - dp_seen[i] takes the latched DP value.
  - Frame mask bit i is set.
  - If the pattern is recognised: the nibble is written, digit_err[i]=0 and digit_blank[i]=0.
  - If the pattern is 0x00: the nibble is written as 0, digit_blank[i]=1 and digit_err[i]=0.
  - Otherwise: the nibble is unchanged and digit_err[i]=1.
- Recognised patterns (active-high gfedcba, hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- frame_done:
  - The pulse is asserted on the cycle after the frame mask becomes 8'hFF.
  - The mask is cleared in that same cycle.
- clear:
  - Has priority over a capture in the same cycle.
  - Does not affect the FSM or digits.
- Latency: a stable input appears on the outputs 2 (sync) + SETTLE_CYCLES + 1 cycles after it first appears on the pins.
- Counter width is $clog2(SETTLE_CYCLES+1). The counter saturates and never wraps.
- A reset while in SETTLE abandons the partial count with no capture.

Decomposition:
- Shared package, seg_pkg:
  - Segment pattern constants SEG_0..SEG_F and SEG_BLANK.
  - The FSM state typedef.
  - NUM_DIGITS=8.
- Sub-module seg_to_nibble: combinational; 7-bit active-high pattern in, outputs nibble, hit and blank. It is the exact inverse of the existing decoder table.

Test Plan:
- Static digit: AN=8'hFE, HEX=~7'h4F, DP=1 (dark), held 30 cycles -> digit_valid=8'h01, digits[3:0]=3, digit_err=0, dp_seen=0, capture exactly 2+16+1 cycles after the pins changed.
- Full scan: drive digits 0..7 with values 1..8, 20 cycles each (DP dark) -> digits=32'h87654321, digit_valid=8'hFF, one frame_done pulse after digit 7, none before.
- Glitch rejection: HEX toggles between ~7'h06 and ~7'h5B every 5 cycles for 100 cycles -> no capture; digit_valid stays 0.
- Bad and blank patterns:
  - Digit 2 with HEX=~7'h01 -> digit_err[2]=1, nibble unchanged.
  - Then HEX=~7'h00 -> digit_blank[2]=1, digit_err[2]=0, nibble=0.
- Non-one-hot AN: AN=8'hFC for 50 cycles -> FSM stays IDLE, no capture; a subsequent AN=8'hFB with ~7'h71 -> digit 2 = F.
- Reset and clear:
  - Assert rst_n low mid-SETTLE -> all outputs 0, no capture on release.
  - Pulse clear during a scan -> valid/err/blank/dp_seen zeroed; frame_done waits for 8 new captures.
